// File: rtl/sync_fifo_pkg.sv
// Shared types, default widths and sizing helpers for the flit FIFO.
package sync_fifo_pkg;

  localparam int unsigned SRC_W_DEF  = 8;
  localparam int unsigned DST_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 8;

  typedef struct packed {
    logic [SRC_W_DEF-1:0]  src;
    logic [DST_W_DEF-1:0]  dst;
    logic [DATA_W_DEF-1:0] data;
  } flit_t;

  // Encoding is {wr_ok, rd_ok} so the accept pair casts directly.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// 1W/1R register array with asynchronous read; kept separate so a RAM macro can replace it.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PTR_W = ptr_w(DEPTH),
  parameter type         word_t = flit_t
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  word_t            wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output word_t            rdata_o
);

  word_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised flit FIFO: pointers, occupancy count, threshold/error flags and read port.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int unsigned SRC_W  = SRC_W_DEF,
  parameter int unsigned DST_W  = DST_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 1,
  parameter int unsigned FWFT   = 0,
  parameter int unsigned CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [SRC_W-1:0]  src_in,
  input  logic [DST_W-1:0]  dst_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              writep,
  input  logic              readp,
  input  logic              clr_errp,
  output logic [SRC_W-1:0]  src_out,
  output logic [DST_W-1:0]  dst_out,
  output logic [DATA_W-1:0] data_out,
  output logic              emptyp,
  output logic              fullp,
  output logic              almostfullp,
  output logic              almostemptyp,
  output logic [CNT_W-1:0]  count,
  output logic              overflowp,
  output logic              underflowp
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DST_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } word_t;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  word_t            out_q, out_d;
  word_t            wr_word, rd_word, shown;
  logic             empty, full, wr_ok, rd_ok;
  op_e              op;

  // Flags come only from the registered count, never from readp/writep.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  assign rd_ok = readp && !empty;
  assign wr_ok = writep && (!full || rd_ok);
  assign op    = op_e'({wr_ok, rd_ok});

  assign wr_word = '{src: src_in, dst: dst_in, data: data_in};

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .word_t(word_t)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (wr_ok),
    .waddr_i(head_q),
    .wdata_i(wr_word),
    .raddr_i(tail_q),
    .rdata_o(rd_word)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case (op)
      OP_PUSH: begin
        head_d  = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end
      OP_POP: begin
        tail_d  = tail_q + PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
      OP_BOTH: begin
        head_d = head_q + PTR_W'(1);
        tail_d = tail_q + PTR_W'(1);
      end
      default: ;
    endcase
  end

  // A new error in the same cycle as a clear takes priority.
  always_comb begin
    ovf_d = clr_errp ? 1'b0 : ovf_q;
    udf_d = clr_errp ? 1'b0 : udf_q;
    if (writep && !wr_ok) ovf_d = 1'b1;
    if (readp && !rd_ok)  udf_d = 1'b1;
  end

  always_comb begin
    out_d = out_q;
    if (rd_ok && (FWFT == 0)) out_d = rd_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      out_q   <= out_d;
    end
  end

  // Fall-through shows the array head; gated to zero while empty since storage is never reset.
  assign shown = (FWFT != 0) ? (empty ? '0 : rd_word) : out_q;

  assign src_out      = shown.src;
  assign dst_out      = shown.dst;
  assign data_out     = shown.data;
  assign emptyp       = empty;
  assign fullp        = full;
  assign almostfullp  = (count_q >= CNT_W'(AF_LVL));
  assign almostemptyp = (count_q <= CNT_W'(AE_LVL));
  assign count        = count_q;
  assign overflowp    = ovf_q;
  assign underflowp   = udf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: registered-read and fall-through instances share stimulus.
module tb_sync_fifo_flex;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  src_in = '0;
  logic [7:0]  dst_in = '0;
  logic [31:0] data_in = '0;
  logic        writep = 1'b0;
  logic        readp = 1'b0;
  logic        clr_errp = 1'b0;

  logic [7:0]  a_src, a_dst, b_src, b_dst;
  logic [31:0] a_data, b_data;
  logic        a_empty, a_full, a_af, a_ae, a_ovf, a_udf;
  logic        b_empty, b_full, b_af, b_ae, b_ovf, b_udf;
  logic [3:0]  a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DEPTH(8), .AF_LVL(6), .AE_LVL(1), .FWFT(0)) dut_a (
    .clk(clk), .rstn(rstn), .src_in(src_in), .dst_in(dst_in), .data_in(data_in),
    .writep(writep), .readp(readp), .clr_errp(clr_errp),
    .src_out(a_src), .dst_out(a_dst), .data_out(a_data),
    .emptyp(a_empty), .fullp(a_full), .almostfullp(a_af), .almostemptyp(a_ae),
    .count(a_cnt), .overflowp(a_ovf), .underflowp(a_udf)
  );

  sync_fifo_flex #(.DEPTH(8), .AF_LVL(6), .AE_LVL(1), .FWFT(1)) dut_b (
    .clk(clk), .rstn(rstn), .src_in(src_in), .dst_in(dst_in), .data_in(data_in),
    .writep(writep), .readp(readp), .clr_errp(clr_errp),
    .src_out(b_src), .dst_out(b_dst), .data_out(b_data),
    .emptyp(b_empty), .fullp(b_full), .almostfullp(b_af), .almostemptyp(b_ae),
    .count(b_cnt), .overflowp(b_ovf), .underflowp(b_udf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus, then return inputs to idle.
  task automatic cyc(input logic w, input logic r, input logic [31:0] d, input logic clr);
    writep   = w;
    readp    = r;
    data_in  = d;
    src_in   = d[7:0];
    dst_in   = d[15:8];
    clr_errp = clr;
    tick();
    writep   = 1'b0;
    readp    = 1'b0;
    clr_errp = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_word;

  initial begin
    // 1: reset state, basic registered reads
    do_reset();
    chk("rst_count", 64'(a_cnt), 64'(0));
    chk("rst_empty", 64'(a_empty), 64'(1));
    chk("rst_ae", 64'(a_ae), 64'(1));
    chk("rst_full", 64'(a_full), 64'(0));
    chk("rst_af", 64'(a_af), 64'(0));
    chk("rst_ovf", 64'(a_ovf), 64'(0));
    chk("rst_udf", 64'(a_udf), 64'(0));
    chk("rst_data", 64'(a_data), 64'(0));
    chk("rst_src", 64'(a_src), 64'(0));
    chk("rst_fwft_data", 64'(b_data), 64'(0));
    cyc(1, 0, 32'h1111, 0);
    cyc(1, 0, 32'h2222, 0);
    cyc(1, 0, 32'h3333, 0);
    chk("t1_cnt3", 64'(a_cnt), 64'(3));
    chk("t1_ae_off", 64'(a_ae), 64'(0));
    chk("t1_noread_hold", 64'(a_data), 64'(0));
    chk("t1_fwft_head", 64'(b_data), 64'h1111);
    cyc(0, 1, '0, 0);
    chk("t1_rd1", 64'(a_data), 64'h1111);
    chk("t1_rd1_src", 64'(a_src), 64'h11);
    chk("t1_cnt2", 64'(a_cnt), 64'(2));
    cyc(0, 1, '0, 0);
    chk("t1_rd2", 64'(a_data), 64'h2222);
    chk("t1_cnt1", 64'(a_cnt), 64'(1));
    chk("t1_ae_on", 64'(a_ae), 64'(1));
    chk("t1_fwft_next", 64'(b_data), 64'h3333);
    cyc(0, 0, '0, 0);
    chk("t1_hold", 64'(a_data), 64'h2222);
    cyc(0, 1, '0, 0);
    chk("t1_rd3", 64'(a_data), 64'h3333);
    chk("t1_empty", 64'(a_empty), 64'(1));

    // 2: fill, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 32'(i), 0);
      chk("t2_cnt", 64'(a_cnt), 64'(i));
      chk("t2_af", 64'(a_af), 64'(i >= 6));
      chk("t2_full", 64'(a_full), 64'(i == 8));
    end
    cyc(1, 0, 32'h9, 0);
    chk("t2_ovf_cnt", 64'(a_cnt), 64'(8));
    chk("t2_ovf", 64'(a_ovf), 64'(1));
    chk("t2_full_hold", 64'(a_full), 64'(1));
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, '0, 0);
      chk("t2_rd", 64'(a_data), 64'(i));
      chk("t2_rd_cnt", 64'(a_cnt), 64'(8 - i));
    end
    chk("t2_empty", 64'(a_empty), 64'(1));
    cyc(0, 1, '0, 0);
    chk("t2_no9", 64'(a_data), 64'h8);
    cyc(0, 0, '0, 1);
    chk("t2_clr_ovf", 64'(a_ovf), 64'(0));
    chk("t2_clr_udf", 64'(a_udf), 64'(0));

    // 3: underflow after reset, clear, set-wins
    do_reset();
    cyc(0, 1, '0, 0);
    chk("t3_udf", 64'(a_udf), 64'(1));
    chk("t3_data", 64'(a_data), 64'(0));
    chk("t3_cnt", 64'(a_cnt), 64'(0));
    cyc(0, 0, '0, 1);
    chk("t3_clr", 64'(a_udf), 64'(0));
    cyc(0, 1, '0, 1);
    chk("t3_setwins", 64'(a_udf), 64'(1));
    cyc(0, 0, '0, 1);
    // write+read into empty: write lands, read rejected
    cyc(1, 1, 32'h77, 0);
    chk("t3_wr_empty_cnt", 64'(a_cnt), 64'(1));
    chk("t3_wr_empty_udf", 64'(a_udf), 64'(1));
    chk("t3_no_bypass", 64'(a_data), 64'(0));
    cyc(0, 1, '0, 1);
    chk("t3_late_rd", 64'(a_data), 64'h77);
    chk("t3_late_clr", 64'(a_udf), 64'(0));

    // 4: full with simultaneous read/write across pointer wrap
    for (int i = 0; i < 8; i++) cyc(1, 0, 32'h100 + 32'(i), 0);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1, 32'h108 + 32'(k), 0);
      chk("t4_rd", 64'(a_data), 64'h100 + 64'(k));
      chk("t4_cnt", 64'(a_cnt), 64'(8));
      chk("t4_full", 64'(a_full), 64'(1));
      chk("t4_ovf", 64'(a_ovf), 64'(0));
    end
    for (int k = 20; k < 28; k++) begin
      cyc(0, 1, '0, 0);
      chk("t4_drain", 64'(a_data), 64'h100 + 64'(k));
    end
    chk("t4_end_cnt", 64'(a_cnt), 64'(0));

    // 5: fall-through
    do_reset();
    cyc(1, 0, 32'hABCD, 0);
    chk("t5_fwft_data", 64'(b_data), 64'hABCD);
    chk("t5_fwft_dst", 64'(b_dst), 64'hAB);
    chk("t5_fwft_nempty", 64'(b_empty), 64'(0));
    chk("t5_reg_hold", 64'(a_data), 64'(0));
    cyc(0, 0, '0, 0);
    chk("t5_fwft_stay", 64'(b_data), 64'hABCD);
    cyc(0, 1, '0, 0);
    chk("t5_fwft_empty", 64'(b_empty), 64'(1));
    chk("t5_reg_rd", 64'(a_data), 64'hABCD);

    // 6: asynchronous reset mid-burst
    do_reset();
    cyc(0, 1, '0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h200 + 32'(i), 0);
    chk("t6_cnt5", 64'(a_cnt), 64'(5));
    chk("t6_udf_set", 64'(a_udf), 64'(1));
    writep = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_cnt", 64'(a_cnt), 64'(0));
    chk("t6_async_empty", 64'(a_empty), 64'(1));
    chk("t6_async_udf", 64'(a_udf), 64'(0));
    chk("t6_async_fwft_cnt", 64'(b_cnt), 64'(0));
    tick();
    writep = 1'b0;
    rstn = 1'b1;
    cyc(1, 0, 32'h5555, 0);
    cyc(0, 1, '0, 0);
    chk("t6_after", 64'(a_data), 64'h5555);
    chk("t6_after_cnt", 64'(a_cnt), 64'(0));

    // 7: random soak against a queue model
    do_reset();
    q.delete();
    for (int n = 0; n < 1000; n++) begin
      logic w, r;
      logic [31:0] d;
      w = (q.size() < 8) && ($urandom_range(0, 1) == 1);
      r = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      d = $urandom;
      exp_word = (q.size() > 0) ? q[0] : '0;
      if (q.size() > 0) chk("t7_fwft", 64'(b_data), 64'(exp_word));
      cyc(w, r, d, 0);
      if (r) void'(q.pop_front());
      if (w) q.push_back(d);
      chk("t7_cnt", 64'(a_cnt), 64'(q.size()));
      if (r) chk("t7_rd", 64'({a_src, a_data}), 64'({exp_word[7:0], exp_word}));
    end
    chk("t7_ovf", 64'(a_ovf), 64'(0));
    chk("t7_udf", 64'(a_udf), 64'(0));
    chk("t7_fwft_cnt", 64'(b_cnt), 64'(q.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
